// File: rtl/s16x4a_bus_responder_if.sv
// 16-bit word bus between one initiator and one memory-mapped responder.
// Latency: none, this is only a bundle of wires.
// Backpressure: the responder stretches a cycle by withholding ack_o; abort_o is valid only with ack_o.
interface s16x4a_bus_responder_if;
    logic [15:1] adr_i;
    logic        cyc_i;
    logic        stb_i;
    logic        we_i;
    logic [1:0]  sel_i;
    logic        vda_i;
    logic        vpa_i;
    logic [15:0] dat_i;
    logic [15:0] dat_o;
    logic        ack_o;
    logic        abort_o;

    modport master (
        output adr_i, cyc_i, stb_i, we_i, sel_i, vda_i, vpa_i, dat_i,
        input  dat_o, ack_o, abort_o
    );

    modport slave (
        input  adr_i, cyc_i, stb_i, we_i, sel_i, vda_i, vpa_i, dat_i,
        output dat_o, ack_o, abort_o
    );
endinterface

// File: rtl/s16x4a_bus_responder.sv
// Word-addressed RAM responder with a write-protected low region and a fixed wait count.
// Latency: ack_o is high in the (WAIT+1)th cycle after the request edge; one access per WAIT+2 cycles.
// Backpressure: dropping cyc_i/stb_i during the wait cancels the access; the initiator sees no ack.
module s16x4a_bus_responder #(
    parameter logic [15:0] BASE       = 16'h0000,
    parameter int          DEPTH_LOG2 = 8,
    parameter int          WAIT       = 1,
    parameter int          ROM_WORDS  = 16
) (
    input  logic                     clk_i,
    input  logic                     res_i,
    s16x4a_bus_responder_if.slave    bus
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    // Wait counter preload; with WAIT=0 the counter is never used.
    localparam logic [3:0] WCNT_LOAD = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK
    } state_t;

    state_t                  state_q;
    state_t                  state_nxt;
    logic [3:0]              wcnt_q;
    logic [3:0]              wcnt_nxt;

    // Request attributes latched at the request edge.
    logic [DEPTH_LOG2-1:0]   cap_idx_q;
    logic                    cap_we_q;
    logic [1:0]              cap_sel_q;
    logic [15:0]             cap_dat_q;

    // Registered outputs.
    logic                    ack_q;
    logic                    abort_q;
    logic [15:0]             dat_q;

    logic [15:0]             ram [DEPTH];

    logic                    hit;
    logic                    req;
    logic                    active;
    logic                    cap_ld;
    logic                    enter_ack;

    // Operands of the access completing this edge: straight from the bus on a
    // zero-wait hit in IDLE, otherwise from the capture registers.
    logic [DEPTH_LOG2-1:0]   acc_idx;
    logic                    acc_we;
    logic [1:0]              acc_sel;
    logic [15:0]             acc_dat;
    logic                    acc_rom;
    logic                    wr_en;

    // The qualifiers carry no meaning for this responder.
    logic                    unused_qual;
    assign unused_qual = bus.vda_i ^ bus.vpa_i;

    // Window decode on the address bits above the RAM index.
    generate
        if (DEPTH_LOG2 >= 15) begin : g_full_window
            assign hit = 1'b1;
        end else begin : g_window
            assign hit = (bus.adr_i[15:DEPTH_LOG2+1] == BASE[15:DEPTH_LOG2+1]);
        end
    endgenerate

    assign active = bus.cyc_i & bus.stb_i;
    assign req    = active & hit;

    // Next-state logic: request sampling, wait countdown, cancellation, one-cycle ack.
    always_comb begin
        state_nxt = state_q;
        wcnt_nxt  = wcnt_q;
        cap_ld    = 1'b0;
        enter_ack = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    cap_ld = 1'b1;
                    if (WAIT == 0) begin
                        state_nxt = ST_ACK;
                        enter_ack = 1'b1;
                    end else begin
                        state_nxt = ST_WAIT;
                        wcnt_nxt  = WCNT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (!active) begin
                    // Initiator gave up: no write, no ack.
                    state_nxt = ST_IDLE;
                    wcnt_nxt  = 4'd0;
                end else if (wcnt_q == 4'd0) begin
                    state_nxt = ST_ACK;
                    enter_ack = 1'b1;
                end else begin
                    wcnt_nxt = wcnt_q - 4'd1;
                end
            end
            ST_ACK: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
                wcnt_nxt  = 4'd0;
            end
        endcase
    end

    // Select the operands of the access that enters ACK at this edge.
    always_comb begin
        if (state_q == ST_IDLE) begin
            acc_idx = bus.adr_i[DEPTH_LOG2:1];
            acc_we  = bus.we_i;
            acc_sel = bus.sel_i;
            acc_dat = bus.dat_i;
        end else begin
            acc_idx = cap_idx_q;
            acc_we  = cap_we_q;
            acc_sel = cap_sel_q;
            acc_dat = cap_dat_q;
        end
    end

    assign acc_rom = (32'(acc_idx) < 32'(ROM_WORDS));

    // A write held in reset must not land in the RAM, which has no reset of its own.
    assign wr_en = enter_ack & acc_we & ~acc_rom & res_i;

    // FSM state, capture registers and registered bus outputs.
    always_ff @(posedge clk_i or negedge res_i) begin
        if (!res_i) begin
            state_q   <= ST_IDLE;
            wcnt_q    <= 4'd0;
            cap_idx_q <= '0;
            cap_we_q  <= 1'b0;
            cap_sel_q <= 2'b00;
            cap_dat_q <= 16'h0000;
            ack_q     <= 1'b0;
            abort_q   <= 1'b0;
            dat_q     <= 16'h0000;
        end else begin
            state_q <= state_nxt;
            wcnt_q  <= wcnt_nxt;
            if (cap_ld) begin
                cap_idx_q <= bus.adr_i[DEPTH_LOG2:1];
                cap_we_q  <= bus.we_i;
                cap_sel_q <= bus.sel_i;
                cap_dat_q <= bus.dat_i;
            end
            ack_q   <= enter_ack;
            abort_q <= enter_ack & acc_we & acc_rom;
            // Full word regardless of sel; zero whenever not acking.
            dat_q   <= enter_ack ? ram[acc_idx] : 16'h0000;
        end
    end

    // Byte-lane RAM write on entry to ACK; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            if (acc_sel[0]) begin
                ram[acc_idx][7:0] <= acc_dat[7:0];
            end
            if (acc_sel[1]) begin
                ram[acc_idx][15:8] <= acc_dat[15:8];
            end
        end
    end

    assign bus.ack_o   = ack_q;
    assign bus.abort_o = abort_q;
    assign bus.dat_o   = dat_q;

endmodule

// File: doc/s16x4a_bus_responder.md
S16X4A_BUS_RESPONDER -- requirements
Module: s16x4a_bus_responder

Interface
REQ-001 SHALL have parameter BASE, default 0: word-address window base; hit when adr_i[15:DEPTH_LOG2+1] == BASE[15:DEPTH_LOG2+1].
REQ-002 SHALL have parameter DEPTH_LOG2, default 8: internal RAM holds 2^DEPTH_LOG2 16-bit words, indexed by adr_i[DEPTH_LOG2:1].
REQ-003 SHALL have parameter WAIT, default 1 (range 0..15): wait cycles inserted before ack.
REQ-004 SHALL have parameter ROM_WORDS, default 16: window words 0..ROM_WORDS-1 are write-protected.
REQ-005 SHALL have port clk_i  in  1  single clock; all state changes on rising edge.
REQ-006 SHALL have port res_i  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port adr_i  in  15 [15:1]  word address from initiator.
REQ-008 SHALL have ports cyc_i, stb_i, we_i  in  1 each  bus cycle, strobe, write enable.
REQ-009 SHALL have port sel_i  in  2  byte lanes; bit1=dat[15:8], bit0=dat[7:0].
REQ-010 SHALL have ports vda_i, vpa_i  in  1 each  data/program qualifiers; informational only, no effect on behaviour.
REQ-011 SHALL have port dat_i  in  16  write data.
REQ-012 SHALL have port dat_o  out  16  read data.
REQ-013 SHALL have port ack_o  out  1  cycle termination.
REQ-014 SHALL have port abort_o  out  1  access rejected, valid only with ack_o.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, ACK.
REQ-016 A request SHALL be cyc_i & stb_i & hit, sampled at a rising edge in IDLE.
- Request in IDLE, WAIT>0: load wcnt=WAIT-1, go WAIT.
- Request in IDLE, WAIT=0: go ACK.
- No request in IDLE: stay in IDLE.
REQ-017 In WAIT, each edge with cyc_i&stb_i SHALL decrement wcnt (4-bit), moving to ACK at the edge where wcnt==0; a request SHALL therefore see ack_o high exactly WAIT+1 cycles after the sampling edge.
REQ-018 In WAIT, cyc_i or stb_i low at an edge SHALL return FSM to IDLE with no RAM write and no ack (cancelled cycle).
REQ-019 Address, we, sel and write data SHALL be captured at the request edge and held in a register; later changes of the inputs SHALL be ignored until the next IDLE.
REQ-020 ack_o SHALL be high for exactly one cycle, while in ACK, then the FSM SHALL return to IDLE unconditionally.
REQ-021 Back-to-back: if cyc_i&stb_i&hit is still high in the cycle after ACK, it SHALL count as a new request; minimum access period is WAIT+2 cycles.
REQ-022 Read: on entry to ACK, dat_o SHALL be loaded with the full RAM word at the captured address, both lanes regardless of sel; dat_o SHALL be 16'h0000 outside ACK.
REQ-023 Write: on entry to ACK, RAM bytes SHALL be updated only where the captured sel bit is 1; sel=00 writes nothing but still acks.
REQ-024 A write whose captured index < ROM_WORDS SHALL leave RAM unchanged, and abort_o SHALL be asserted with ack_o in ACK; reads of ROM words SHALL never abort.
REQ-025 abort_o SHALL be 0 whenever ack_o is 0.
REQ-026 A miss (address outside window) SHALL produce no ack, no abort, and no RAM access; the FSM SHALL stay in IDLE.
REQ-027 ack_o, abort_o and dat_o SHALL be registered outputs with no combinational path from any input.

Reset
REQ-028 res_i low SHALL immediately force FSM=IDLE, wcnt=0, ack_o=0, abort_o=0, dat_o=16'h0000, including in the middle of an access; the pending write SHALL be dropped.
REQ-029 RAM contents SHALL NOT be reset.
REQ-030 The first request SHALL be sampled on the first rising edge after res_i deasserts high.

Verification
REQ-031 WAIT=1, BASE=0: write 16'hBEEF to adr 0x20, sel=11 -> ack one cycle, 2 cycles after sampling edge; abort_o=0; read back gives dat_o=16'hBEEF during ack.
REQ-032 Byte lanes: write 16'h1234 sel=01, then 16'hAB00 sel=10 to a word holding 16'hBEEF -> readback 16'hAB34.
REQ-033 ROM_WORDS=16: write 16'hFFFF to adr 0x05 -> ack_o=1 and abort_o=1 in the same cycle; subsequent read returns the original word.
REQ-034 Start a read with WAIT=3, drop cyc_i after 1 wait cycle -> no ack ever; the next request is accepted normally.
REQ-035 Hold cyc_i/stb_i high over 3 consecutive reads with WAIT=0 -> ack every 2nd cycle with correct data; miss address 0xFF00 (BASE=0, DEPTH_LOG2=8) -> no ack for 20 cycles.
REQ-036 Assert res_i low during WAIT of a write -> outputs zero immediately; after release, readback shows the old value.
